// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues one outstanding imem request at a time,
// and buffers fetched {instruction, PC+4} pairs for IF/ID. Optional macro: FETCHQ_BYPASS_EN.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic                       imem_req_o,
    output logic [31:0]                imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [31:0]                imem_data_i,
    input  logic                       deq_i,
    output logic                       inst_valid_o,
    output logic [31:0]                inst_o,
    output logic [31:0]                pc4_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_reg;
    logic [31:0]   addr_reg;
    logic          pending_reg;
    logic          discard_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   inst_reg;
    logic [31:0]   pc4_reg;
    logic          valid_reg;
    logic [63:0]   mem [DEPTH];

    logic          ack_live;
    logic          ack_take;
    logic          bypass_consume;
    logic          push;
    logic          pop;
    logic          issue;
    logic          head_is_new;
    logic [31:0]   pc4_new;
    logic [31:0]   redirect_pc_aligned;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] wr_ptr_next;
    logic [CW-1:0] count_next;

    assign redirect_pc_aligned = {redirect_pc_i[31:2], 2'b00};
    assign pc4_new  = addr_reg + 32'd4;
    // A response is only meaningful while our request is outstanding.
    assign ack_live = pending_reg & imem_ack_i;
    assign ack_take = ack_live & ~discard_reg & ~redirect_i;
    assign pop      = deq_i & valid_reg & ~redirect_i;
    assign issue    = start_i & ~pending_reg & (count_reg < CW'(DEPTH));

`ifdef FETCHQ_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit     = ack_take & (count_reg == '0);
    assign bypass_consume = bypass_hit & deq_i;
    assign inst_o         = bypass_hit ? imem_data_i : inst_reg;
    assign pc4_o          = bypass_hit ? pc4_new : pc4_reg;
    assign inst_valid_o   = bypass_hit | valid_reg;
`else
    assign bypass_consume = 1'b0;
    assign inst_o         = inst_reg;
    assign pc4_o          = pc4_reg;
    assign inst_valid_o   = valid_reg;
`endif

    assign push = ack_take & ~bypass_consume;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        head_is_new = 1'b0;
        if (redirect_i) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (pop)
                rd_ptr_next = rd_ptr_reg + {{(PW-1){1'b0}}, 1'b1};
            if (push)
                wr_ptr_next = wr_ptr_reg + {{(PW-1){1'b0}}, 1'b1};
            if (push && !pop)
                count_next = count_reg + {{(CW-1){1'b0}}, 1'b1};
            else if (pop && !push)
                count_next = count_reg - {{(CW-1){1'b0}}, 1'b1};
            // Pushed entry becomes the head when nothing older survives this edge.
            head_is_new = push && (count_reg == {{(CW-1){1'b0}}, pop});
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr_reg] <= {imem_data_i, pc4_new};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_reg <= RESET_PC;
            addr_reg     <= RESET_PC;
            pending_reg  <= 1'b0;
            discard_reg  <= 1'b0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            inst_reg     <= 32'h0;
            pc4_reg      <= 32'h0;
            valid_reg    <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;

            if (redirect_i)
                fetch_pc_reg <= redirect_pc_aligned;
            else if (ack_take)
                fetch_pc_reg <= fetch_pc_reg + 32'd4;

            if (ack_live)
                pending_reg <= 1'b0;
            else if (issue)
                pending_reg <= 1'b1;

            // A redirect arriving with no pending request can issue straight at the new target.
            if (issue)
                addr_reg <= redirect_i ? redirect_pc_aligned : fetch_pc_reg;

            if (ack_live)
                discard_reg <= 1'b0;
            else if (redirect_i && pending_reg)
                discard_reg <= 1'b1;

            if (count_next == '0) begin
                inst_reg  <= 32'h0;
                pc4_reg   <= 32'h0;
                valid_reg <= 1'b0;
            end else if (head_is_new) begin
                inst_reg  <= imem_data_i;
                pc4_reg   <= pc4_new;
                valid_reg <= 1'b1;
            end else begin
                inst_reg  <= mem[rd_ptr_next][63:32];
                pc4_reg   <= mem[rd_ptr_next][31:0];
                valid_reg <= 1'b1;
            end
        end
    end

    assign imem_req_o  = pending_reg;
    assign imem_addr_o = addr_reg;
    assign count_o     = count_reg;

endmodule
